alu_issue_ctrl: RTL and testbench

Multi-cycle issue/writeback controller that drives the combinational 8-bit ALU. It accepts 9-bit instructions over a valid/ready handshake and decodes them to the ALU opcode and operands. It reads the operands from an internal 8x8 register file, captures alu_result/alu_zero, writes back, and reports branch outcome. It sits between fetch and the ALU in the custom 8-bit CPU.

---
 rtl/alu_issue_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU: IDLE -> ISSUE -> WB, with an 8x8 register file.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN: an illegal op locks the controller in TRAP until reset.
module alu_issue_ctrl #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [8:0]    instr,
    output logic          instr_ready,
    output logic [2:0]    alu_instruction,
    output logic [DW-1:0] alu_input1,
    output logic [DW-1:0] alu_input2,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          done,
    output logic          branch_taken,
    output logic          illegal,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int unsigned OPW = 3;
    localparam int unsigned AW  = 3;
    localparam int unsigned IMW = 3;

    localparam logic [OPW-1:0] OP_XOR  = 3'b000;
    localparam logic [OPW-1:0] OP_BEQ  = 3'b001;
    localparam logic [OPW-1:0] OP_ADDI = 3'b010;
    localparam logic [OPW-1:0] OP_ANDI = 3'b011;
    localparam logic [OPW-1:0] OP_LS   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        S_WB    = 2'd2,
        S_TRAP  = 2'd3
`else
        S_WB    = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [AW-1:0]   ra_q, ra_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [DW-1:0]   in1_q, in1_d;
    logic [DW-1:0]   in2_q, in2_d;
    logic [DW-1:0]   res_q, res_d;
    logic            done_q, done_d;
    logic            br_q, br_d;
    logic            ill_q, ill_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];

    logic [OPW-1:0]  dec_op;
    logic [AW-1:0]   dec_ra;
    logic [AW-1:0]   dec_rb;
    logic [IMW-1:0]  dec_imm;
    logic [DW-1:0]   dec_in1;
    logic [DW-1:0]   dec_in2;
    logic            q_wr_en;
    logic            q_illegal;

    assign dec_op  = instr[8:6];
    assign dec_ra  = instr[5:3];
    assign dec_rb  = instr[2:0];
    assign dec_imm = instr[2:0];

    // Operand selection for the incoming instruction; illegal ops drive zero operands.
    always_comb begin
        dec_in1 = '0;
        dec_in2 = '0;
        case (dec_op)
            OP_XOR, OP_BEQ: begin
                dec_in1 = regs_q[dec_ra];
                dec_in2 = regs_q[dec_rb];
            end
            OP_ADDI: begin
                dec_in1 = regs_q[dec_ra];
                dec_in2 = {{(DW-IMW){dec_imm[IMW-1]}}, dec_imm};
            end
            OP_ANDI, OP_LS: begin
                dec_in1 = regs_q[dec_ra];
                dec_in2 = DW'(dec_imm);
            end
            default: begin
                dec_in1 = '0;
                dec_in2 = '0;
            end
        endcase
    end

    assign q_wr_en   = (op_q == OP_XOR) || (op_q == OP_ADDI) ||
                       (op_q == OP_ANDI) || (op_q == OP_LS);
    assign q_illegal = (op_q > OP_LS);

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        op_d     = op_q;
        ra_d     = ra_q;
        alu_op_d = alu_op_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        res_d    = res_q;
        done_d   = 1'b0;
        br_d     = 1'b0;
        ill_d    = 1'b0;
        regs_d   = regs_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (ready_q && instr_valid) begin
                    state_d  = S_ISSUE;
                    ready_d  = 1'b0;
                    op_d     = dec_op;
                    ra_d     = dec_ra;
                    alu_op_d = dec_op;
                    in1_d    = dec_in1;
                    in2_d    = dec_in2;
                end
            end
            S_ISSUE: begin
                state_d = S_WB;
                ready_d = 1'b0;
                res_d   = alu_result;
                done_d  = 1'b1;
                br_d    = (op_q == OP_BEQ) && alu_zero;
                ill_d   = q_illegal;
            end
            S_WB: begin
                if (q_wr_en) begin
                    regs_d[ra_q] = res_q;
                end
                state_d = S_IDLE;
                ready_d = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                if (q_illegal) begin
                    state_d = S_TRAP;
                    ready_d = 1'b0;
                end
`endif
            end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ready_d = 1'b0;
            end
`endif
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            op_q     <= '0;
            ra_q     <= '0;
            alu_op_q <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            op_q     <= op_d;
            ra_q     <= ra_d;
            alu_op_q <= alu_op_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            res_q    <= res_d;
            done_q   <= done_d;
            br_q     <= br_d;
            ill_q    <= ill_d;
            regs_q   <= regs_d;
        end
    end

    assign instr_ready     = ready_q;
    assign alu_instruction = alu_op_q;
    assign alu_input1      = in1_q;
    assign alu_input2      = in2_q;
    assign done            = done_q;
    assign branch_taken    = br_q;
    assign illegal         = ill_q;
    assign dbg_data        = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [2:0] alu_instruction;
    logic [7:0] alu_input1;
    logic [7:0] alu_input2;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       done;
    logic       branch_taken;
    logic       illegal;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;
    int regs_m [8];

    alu_issue_ctrl u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_ready     (instr_ready),
        .alu_instruction (alu_instruction),
        .alu_input1      (alu_input1),
        .alu_input2      (alu_input2),
        .alu_result      (alu_result),
        .alu_zero        (alu_zero),
        .done            (done),
        .branch_taken    (branch_taken),
        .illegal         (illegal),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Stand-in combinational ALU; shift code bit 2 = left by one, else right by code[1:0].
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a ^ b;
            3'd1:    return a - b;
            3'd2:    return a + b;
            3'd3:    return a & b;
            3'd4:    return b[2] ? (a << 1) : (a >> b[1:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_instruction, alu_input1, alu_input2);
    assign alu_zero   = (alu_result == 8'h00);

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("dbg_r%0d", i), int'(dbg_data), regs_m[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("rst_ready",  int'(instr_ready), 0);
        check("rst_done",   int'(done), 0);
        check("rst_branch", int'(branch_taken), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_aluop",  int'(alu_instruction), 0);
        check("rst_in1",    int'(alu_input1), 0);
        check("rst_in2",    int'(alu_input2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) regs_m[i] = 0;
        @(posedge clk);
        #1;
        check("rel_ready", int'(instr_ready), 1);
        check_regs();
    endtask

    // Issue one instruction and check issue, writeback and retirement against the model.
    task automatic run_instr(input logic [8:0] ins, input bit hold);
        int op, ra, rb, imm, sv, e_in1, e_in2, e_new, waitc;
        bit e_wr, e_br, e_ill;
        op  = int'(ins[8:6]);
        ra  = int'(ins[5:3]);
        rb  = int'(ins[2:0]);
        imm = rb;
        sv  = (imm >= 4) ? imm - 8 : imm;
        e_in1 = 0; e_in2 = 0; e_new = 0; e_wr = 0; e_br = 0; e_ill = 0;
        case (op)
            0: begin e_in1 = regs_m[ra]; e_in2 = regs_m[rb]; e_new = regs_m[ra] ^ regs_m[rb]; e_wr = 1; end
            1: begin e_in1 = regs_m[ra]; e_in2 = regs_m[rb]; e_br = (regs_m[ra] == regs_m[rb]); end
            2: begin e_in1 = regs_m[ra]; e_in2 = sv & 255; e_new = (regs_m[ra] + sv) & 255; e_wr = 1; end
            3: begin e_in1 = regs_m[ra]; e_in2 = imm; e_new = regs_m[ra] & imm; e_wr = 1; end
            4: begin
                e_in1 = regs_m[ra]; e_in2 = imm; e_wr = 1;
                e_new = (imm >= 4) ? ((regs_m[ra] * 2) & 255) : (regs_m[ra] >> (imm % 4));
            end
            default: e_ill = 1;
        endcase

        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        waitc       = 0;
        while (instr_ready !== 1'b1 && waitc < 16) begin
            @(negedge clk);
            waitc++;
        end
        if (instr_ready !== 1'b1) begin
            check("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        check("issue_ready", int'(instr_ready), 0);
        check("issue_done",  int'(done), 0);
        check("alu_op",      int'(alu_instruction), op);
        check("alu_in1",     int'(alu_input1), e_in1);
        check("alu_in2",     int'(alu_input2), e_in2);
        @(posedge clk);
        #1;
        check("wb_done",    int'(done), 1);
        check("wb_branch",  int'(branch_taken), int'(e_br));
        check("wb_illegal", int'(illegal), int'(e_ill));
        check("wb_ready",   int'(instr_ready), 0);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_done",    int'(done), 0);
        check("post_branch",  int'(branch_taken), 0);
        check("post_illegal", int'(illegal), 0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        check("post_ready", int'(instr_ready), e_ill ? 0 : 1);
`else
        check("post_ready", int'(instr_ready), 1);
`endif
        if (e_wr) regs_m[ra] = e_new;
        check_regs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int waitc;
        int op;
        logic [8:0] rnd;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        for (int i = 0; i < 8; i++) regs_m[i] = 0;
        do_reset();

        // addi R1,+3, then addi R2,-4 twice, xor R1,R2
        run_instr(9'b010_001_011, 1'b0);
        run_instr(9'b010_010_100, 1'b0);
        run_instr(9'b010_010_100, 1'b0);
        run_instr(9'b000_001_010, 1'b0);

        // R1 = R3 = 5, beq R1,R3 taken, beq R1,R0 not taken
        run_instr(9'b011_001_000, 1'b0);
        run_instr(9'b010_001_011, 1'b0);
        run_instr(9'b010_001_010, 1'b0);
        run_instr(9'b011_011_000, 1'b0);
        run_instr(9'b010_011_011, 1'b0);
        run_instr(9'b010_011_010, 1'b0);
        run_instr(9'b001_001_011, 1'b0);
        run_instr(9'b001_001_000, 1'b0);

        // R4 = 0x40 via shifts, then ls 001, ls 111, andi 7
        run_instr(9'b011_100_000, 1'b0);
        run_instr(9'b010_100_001, 1'b0);
        repeat (6) run_instr(9'b100_100_111, 1'b0);
        run_instr(9'b100_100_001, 1'b0);
        run_instr(9'b100_100_111, 1'b0);
        run_instr(9'b011_100_111, 1'b0);

        // Illegal op 110
        run_instr(9'b110_011_101, 1'b0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        repeat (6) begin
            @(posedge clk);
            #1;
            check("trap_ready", int'(instr_ready), 0);
        end
        do_reset();
`else
        run_instr(9'b010_110_010, 1'b0);
`endif

        // Reset during ISSUE of addi R5,+1
        @(negedge clk);
        instr       = 9'b010_101_001;
        instr_valid = 1'b1;
        waitc       = 0;
        while (instr_ready !== 1'b1 && waitc < 16) begin
            @(negedge clk);
            waitc++;
        end
        check("mid_accept", int'(instr_ready), 1);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("mid_done",  int'(done), 0);
        check("mid_ready", int'(instr_ready), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_done_hold", int'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) regs_m[i] = 0;
        @(posedge clk);
        #1;
        check("mid_rel_ready", int'(instr_ready), 1);
        check_regs();
        run_instr(9'b010_101_001, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("once_done", int'(done), 0);
        end
        check_regs();

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            op = int'($urandom_range(0, 4));
`else
            op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
`endif
            rnd = {3'(op), 6'($urandom_range(0, 63))};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_instr(rnd, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
